// File: rtl/vdma_pattern_source.sv
`timescale 1ns/1ps
// AXI4-Stream test-pattern source producing VDMA-style line-packed words with tuser/tlast framing.
// Latency: control ops take effect 2 cycles after presentation; geometry applies from the next frame start.
// Backpressure: outputs are registered and held stable while tvalid && !tready.
module vdma_pattern_source #(
    parameter int HBLANK_CYCLES = 16,
    parameter int VBLANK_CYCLES = 64
) (
    input  logic        m_axis_vid_aclk,
    input  logic        areset,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    input  logic [31:0] control_data,
    input  logic [7:0]  control_op,
    output logic [15:0] dbg_line,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LINE   = 2'd1;
    localparam logic [1:0] ST_HBLANK = 2'd2;
    localparam logic [1:0] ST_VBLANK = 2'd3;

    localparam logic [7:0] OP_COLORMODE  = 8'd1;
    localparam logic [7:0] OP_DIMENSIONS = 8'd2;
    localparam logic [7:0] OP_PATTERN    = 8'd5;
    localparam logic [7:0] OP_ENABLE     = 8'd6;

    logic [7:0]  op_q;
    logic [31:0] data_q;
    logic [15:0] cfg_width, cfg_height, sh_width, sh_height;
    logic [1:0]  cfg_cm, cfg_pat, sh_cm, sh_pat;
    logic [23:0] cfg_solid, sh_solid;
    logic        cfg_en;

    logic [1:0]  state;
    logic [15:0] word_cnt, line_cnt, gap_cnt;
    logic [16:0] wpl;
    logic        last_word, next_is_last, first_is_last, last_line, hb_done, vb_done;

    always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
        if (areset) begin
            op_q       <= 8'd0;
            data_q     <= 32'd0;
            cfg_width  <= 16'd640;
            cfg_height <= 16'd480;
            cfg_cm     <= 2'd1;
            cfg_pat    <= 2'd0;
            cfg_solid  <= 24'd0;
            cfg_en     <= 1'b0;
        end else begin
            op_q   <= control_op;
            data_q <= control_data;
            case (op_q)
                OP_COLORMODE:  cfg_cm <= data_q[1:0];
                OP_DIMENSIONS: begin
                    cfg_height <= data_q[31:16];
                    cfg_width  <= data_q[15:0];
                end
                OP_PATTERN: begin
                    cfg_pat   <= data_q[25:24];
                    cfg_solid <= data_q[23:0];
                end
                OP_ENABLE:     cfg_en <= data_q[0];
                default: ;
            endcase
        end
    end

    // Words per line from the frame's shadow geometry; 17 bits so width+3 cannot wrap.
    always_comb begin
        case (sh_cm)
            2'd0:    wpl = ({1'b0, sh_width} + 17'd3) >> 2;
            2'd1:    wpl = ({1'b0, sh_width} + 17'd1) >> 1;
            default: wpl = {1'b0, sh_width};
        endcase
    end

    assign last_word     = ({1'b0, word_cnt} + 17'd1) == wpl;
    assign next_is_last  = ({1'b0, word_cnt} + 17'd2) == wpl;
    assign first_is_last = (wpl == 17'd1);
    assign last_line     = (line_cnt + 16'd1) == sh_height;
    assign hb_done       = (HBLANK_CYCLES <= 1) || (gap_cnt == 16'(HBLANK_CYCLES - 1));
    assign vb_done       = (VBLANK_CYCLES <= 1) || (gap_cnt == 16'(VBLANK_CYCLES - 1));

    function automatic logic [31:0] pixel(input logic [15:0] w, input logic [15:0] l,
                                          input logic [1:0] pat, input logic [23:0] solid);
        case (pat)
            2'd0:    pixel = {8'h00, solid};
            2'd2:    pixel = (w[3] ^ l[3]) ? 32'hFFFF_FFFF : 32'h0000_0000;
            default: pixel = {l, w};
        endcase
    endfunction

    always_ff @(posedge m_axis_vid_aclk or posedge areset) begin
        if (areset) begin
            state             <= ST_IDLE;
            word_cnt          <= 16'd0;
            line_cnt          <= 16'd0;
            gap_cnt           <= 16'd0;
            m_axis_vid_tvalid <= 1'b0;
            m_axis_vid_tuser  <= 1'b0;
            m_axis_vid_tlast  <= 1'b0;
            m_axis_vid_tdata  <= 32'd0;
            sh_width          <= 16'd640;
            sh_height         <= 16'd480;
            sh_cm             <= 2'd1;
            sh_pat            <= 2'd0;
            sh_solid          <= 24'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_axis_vid_tvalid <= 1'b0;
                    if (cfg_en && cfg_width != 16'd0 && cfg_height != 16'd0) begin
                        sh_width  <= cfg_width;
                        sh_height <= cfg_height;
                        sh_cm     <= cfg_cm;
                        sh_pat    <= cfg_pat;
                        sh_solid  <= cfg_solid;
                        word_cnt  <= 16'd0;
                        line_cnt  <= 16'd0;
                        state     <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (!m_axis_vid_tvalid) begin
                        m_axis_vid_tvalid <= 1'b1;
                        m_axis_vid_tdata  <= pixel(word_cnt, line_cnt, sh_pat, sh_solid);
                        m_axis_vid_tuser  <= (word_cnt == 16'd0) && (line_cnt == 16'd0);
                        m_axis_vid_tlast  <= last_word;
                    end else if (m_axis_vid_tready) begin
                        if (last_word) begin
                            m_axis_vid_tvalid <= 1'b0;
                            m_axis_vid_tuser  <= 1'b0;
                            m_axis_vid_tlast  <= 1'b0;
                            word_cnt          <= 16'd0;
                            line_cnt          <= line_cnt + 16'd1;
                            gap_cnt           <= 16'd0;
                            state             <= last_line ? ST_VBLANK : ST_HBLANK;
                        end else begin
                            word_cnt          <= word_cnt + 16'd1;
                            m_axis_vid_tdata  <= pixel(word_cnt + 16'd1, line_cnt, sh_pat, sh_solid);
                            m_axis_vid_tuser  <= 1'b0;
                            m_axis_vid_tlast  <= next_is_last;
                        end
                    end
                end
                // Preload the next line's first word so the gap is exactly HBLANK_CYCLES idle cycles.
                ST_HBLANK: begin
                    if (hb_done) begin
                        state             <= ST_LINE;
                        m_axis_vid_tvalid <= 1'b1;
                        m_axis_vid_tdata  <= pixel(16'd0, line_cnt, sh_pat, sh_solid);
                        m_axis_vid_tuser  <= 1'b0;
                        m_axis_vid_tlast  <= first_is_last;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                ST_VBLANK: begin
                    if (vb_done) state <= ST_IDLE;
                    else         gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_line  = line_cnt;
    assign dbg_state = state;

endmodule
